// File: rtl/riscv_v_rf_wb_arbiter.sv
// Writeback arbiter and busy scoreboard for the vector RF's single byte-enabled write port.
// Define RISCV_V_WB_ARB_RR_EN for round-robin arbitration; otherwise the load/store unit has fixed priority.
module riscv_v_rf_wb_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [NUM_BYTES-1:0]  req0_be,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [NUM_BYTES-1:0]  req1_be,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ready,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [NUM_BYTES-1:0]  rf_wr_en,
  output logic [NUM_REGS-1:0]   busy
);

  // Handshake: a transfer happens in any cycle where valid && ready; ready is
  // combinational, never high without its valid, and at most one ready is high.
  logic                  gnt0, gnt1, xfer;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [NUM_BYTES-1:0]  wb_be;
  logic [NUM_REGS-1:0]   busy_clr, busy_n;

`ifdef RISCV_V_WB_ARB_RR_EN
  logic lg;  // last-granted requester; the other one wins a conflict

  always_comb begin
    gnt0 = req0_valid && (!req1_valid || lg);
    gnt1 = req1_valid && (!req0_valid || !lg);
  end

  always_ff @(posedge clk) begin
    if (rst) lg <= 1'b1;
    else if (xfer) lg <= gnt1;
  end
`else
  always_comb begin
    gnt1 = req1_valid;
    gnt0 = req0_valid && !req1_valid;
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 || gnt1;

  always_comb begin
    wb_addr = gnt1 ? req1_addr : req0_addr;
    wb_data = gnt1 ? req1_data : req0_data;
    wb_be   = gnt1 ? req1_be   : req0_be;
  end

  // Clear is applied before the reservation check so a register retiring this
  // cycle can be re-reserved immediately; the set then wins over the clear.
  always_comb begin
    busy_clr  = busy;
    rsv_ready = 1'b0;
    busy_n    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (xfer && (wb_addr == ADDR_WIDTH'(i))) busy_clr[i] = 1'b0;
    end
    busy_n = busy_clr;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_addr == ADDR_WIDTH'(i)) begin
        rsv_ready = !busy_clr[i];
        if (rsv_valid && !busy_clr[i]) busy_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= '0;
      busy       <= '0;
    end else begin
      rf_wr_en <= xfer ? wb_be : '0;
      if (xfer) begin
        rf_wr_addr <= wb_addr;
        rf_wr_data <= wb_data;
      end
      busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_riscv_v_rf_wb_arbiter.sv
// Directed self-checking bench for riscv_v_rf_wb_arbiter; inputs change on the falling edge.
module tb_riscv_v_rf_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [4:0]   req0_addr, req1_addr;
  logic [127:0] req0_data, req1_data;
  logic [15:0]  req0_be, req1_be;
  logic         rsv_valid;
  logic [4:0]   rsv_addr;
  logic         rsv_ready;
  logic [4:0]   rf_wr_addr;
  logic [127:0] rf_wr_data;
  logic [15:0]  rf_wr_en;
  logic [31:0]  busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  riscv_v_rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_be(req0_be),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_be(req1_be),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
    req0_addr = 0; req1_addr = 0; rsv_addr = 0;
    req0_data = 0; req1_data = 0; req0_be = 0; req1_be = 0;
  endtask

  // Expected grant sequence with both requesters continuously valid
  logic exp_gnt[4];

  initial begin
`ifdef RISCV_V_WB_ARB_RR_EN
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state and idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_en", rf_wr_en, 0);
      check("idle_rdy0", req0_ready, 0);
      check("idle_rdy1", req1_ready, 0);
    end
    check("rst_addr", rf_wr_addr, 0);
    check("rst_data", rf_wr_data, 0);

    // Single writeback from requester 0
    req0_valid = 1; req0_addr = 3; req0_data = PAT_A5; req0_be = 16'hFFFF;
    #1;
    check("solo_rdy0", req0_ready, 1);
    check("solo_rdy1", req1_ready, 0);
    @(negedge clk);
    idle_inputs();
    check("solo_addr", rf_wr_addr, 3);
    check("solo_data", rf_wr_data, PAT_A5);
    check("solo_en", rf_wr_en, 16'hFFFF);
    check("solo_busy", busy, 0);
    @(negedge clk);
    check("solo_en_off", rf_wr_en, 0);
    check("solo_addr_hold", rf_wr_addr, 3);
    check("solo_data_hold", rf_wr_data, PAT_A5);

    // Single writeback from requester 1, leaving requester 1 as last grant
    req1_valid = 1; req1_addr = 4; req1_data = 128'h44; req1_be = 16'h00F0;
    #1;
    check("solo1_rdy1", req1_ready, 1);
    check("solo1_rdy0", req0_ready, 0);
    @(negedge clk);
    idle_inputs();
    check("solo1_addr", rf_wr_addr, 4);
    check("solo1_en", rf_wr_en, 16'h00F0);

    // Conflict: both requesters valid for four cycles
    req0_valid = 1; req0_addr = 1; req0_data = 128'h11; req0_be = 16'hFFFF;
    req1_valid = 1; req1_addr = 2; req1_data = 128'h22; req1_be = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        check("arb_addr", rf_wr_addr, exp_gnt[i-1] ? 5'd2 : 5'd1);
        check("arb_en", rf_wr_en, exp_gnt[i-1] ? 16'h0F0F : 16'hFFFF);
      end
      if (i < 4) begin
        #1;
        check("arb_rdy0", req0_ready, !exp_gnt[i]);
        check("arb_rdy1", req1_ready, exp_gnt[i]);
        @(negedge clk);
      end
    end
    idle_inputs();

    // Reserve 7, reject a second reservation, retire with be=0
    rsv_valid = 1; rsv_addr = 7;
    #1;
    check("rsv7_rdy", rsv_ready, 1);
    @(negedge clk);
    check("rsv7_busy", busy, 32'h0000_0080);
    #1;
    check("rsv7_again_rdy", rsv_ready, 0);
    @(negedge clk);
    check("rsv7_still", busy, 32'h0000_0080);
    idle_inputs();
    req0_valid = 1; req0_addr = 7; req0_data = 128'h77; req0_be = 16'h0000;
    #1;
    check("wb7_rdy", req0_ready, 1);
    @(negedge clk);
    idle_inputs();
    check("wb7_busy", busy, 0);
    check("wb7_en", rf_wr_en, 0);
    check("wb7_addr", rf_wr_addr, 7);

    // Same-cycle clear and re-reservation of 5
    rsv_valid = 1; rsv_addr = 5;
    @(negedge clk);
    check("rsv5_busy", busy, 32'h0000_0020);
    req1_valid = 1; req1_addr = 5; req1_data = 128'h55; req1_be = 16'hFFFF;
    #1;
    check("clrset_rsv_rdy", rsv_ready, 1);
    check("clrset_rdy1", req1_ready, 1);
    @(negedge clk);
    idle_inputs();
    check("clrset_busy", busy, 32'h0000_0020);
    check("clrset_addr", rf_wr_addr, 5);

    // Reset during an accepted transfer to 9
    rsv_valid = 1; rsv_addr = 9;
    @(negedge clk);
    idle_inputs();
    check("rsv9_busy", busy, 32'h0000_0220);
    req0_valid = 1; req0_addr = 9; req0_data = 128'h99; req0_be = 16'hFFFF;
    rst = 1;
    #1;
    check("rst_xfer_rdy0", req0_ready, 1);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    check("rst_xfer_en", rf_wr_en, 0);
    check("rst_xfer_busy", busy, 0);
    check("rst_xfer_addr", rf_wr_addr, 0);
    check("rst_xfer_data", rf_wr_data, 0);

    // After reset requester 0 wins the first conflict in either build only if RR
    req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
    #1;
`ifdef RISCV_V_WB_ARB_RR_EN
    check("post_rst_rdy0", req0_ready, 1);
`else
    check("post_rst_rdy0", req0_ready, 0);
`endif
    check("one_hot_ready", req0_ready & req1_ready, 0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_v_rf_wb_arbiter.md
# riscv_v_rf_wb_arbiter

Writeback arbiter and register scoreboard for the vector register file's single byte-enabled write port. Two writeback requesters share that port through valid/ready handshakes: requester 0 is the vector ALU and requester 1 is the vector load/store unit. The arbiter drives the port from a registered output stage. It also keeps a 32-entry busy scoreboard that the issue stage reserves and writeback clears, so decode can detect RAW/WAW hazards.

## Interface
Parameters:
- NUM_REGS, 32, vector registers tracked by the scoreboard.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 128, write data width (VLEN).
- NUM_BYTES, DATA_WIDTH/8 = 16, byte-enable width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  writeback request.
- req0_ready / req1_ready  out  1  grant; transfer when valid && ready.
- req0_addr / req1_addr  in  ADDR_WIDTH  destination register.
- req0_data / req1_data  in  DATA_WIDTH  write data.
- req0_be / req1_be  in  NUM_BYTES  byte enables.
- rsv_valid  in  1  issue stage reserves a destination.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- rf_wr_addr  out  ADDR_WIDTH  to RF wr_addr.
- rf_wr_data  out  DATA_WIDTH  to RF data_in.
- rf_wr_en  out  NUM_BYTES  to RF wr_en.
- busy  out  NUM_REGS  scoreboard, bit i set means register i has a pending write.

## Operation
- Arbitration state: a 1-bit last-grant pointer `lg`.
  - Reset value 1, so requester 0 wins first.
- Only one requester valid: it is granted.
- Both requesters valid:
  - Round-robin: the requester not equal to `lg` is granted.
  - `lg` updates to the winner on every accepted transfer.
- ready is combinational from both valids and `lg`. At most one ready is high per cycle.
- ready is never high without the corresponding valid.
- Once valid is high, a requester holds valid, addr, data and be stable until accepted.
- Output stage:
  - An accepted transfer loads rf_wr_addr, rf_wr_data and rf_wr_en (the requester's be) on the next edge.
  - In a cycle with no transfer, rf_wr_en is loaded with 0.
  - rf_wr_addr and rf_wr_data hold their previous values when there is no transfer.
- Scoreboard set: when rsv_valid && rsv_ready, busy[rsv_addr] sets on the next edge.
- rsv_ready = !busy[rsv_addr], after applying this cycle's clear. A reservation of a register being cleared in the same cycle is therefore accepted.
- Scoreboard clear: an accepted transfer clears busy[addr] on the next edge.
  - Applies even when be is all zero, so fully masked-off instructions still retire.
- Same-cycle clear and set of the same address: the set wins, and the bit stays 1.
- Writeback to a register whose busy bit is clear: the write proceeds, and busy is unchanged.
- Reset:
  - busy = 0, rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, `lg` = 1.
  - A request in flight at reset is dropped and is not written to the RF.

## Timing
- Handshake in cycle N: RF port registers driven in cycle N+1, RF array updated at end of N+1.
- Writeback-to-read latency: the RF's async read bypass returns the data during cycle N+1.
- busy bit clears in cycle N+1, in step with the write to the RF.
- Reservation in cycle N: busy visible in cycle N+1.
- Throughput: one writeback per cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- rsv_ready, req*_ready: combinational, no dependence on the output stage. No backpressure from the RF.

## Configuration
- `RISCV_V_WB_ARB_RR_EN` defined: round-robin arbitration as above.
- `RISCV_V_WB_ARB_RR_EN` undefined:
  - Fixed priority, requester 1 (load/store) always wins a conflict.
  - The `lg` register is not implemented.
  - Requester 0 may starve while requester 1 stays valid.
  - All other behaviour is identical.

## Test plan
- Reset, then idle: busy=0, rf_wr_en=0 every cycle, both ready=0.
- req0 only, addr=3, data=128'hA5…, be=16'hFFFF at cycle N:
  - req0_ready=1 in N.
  - rf_wr_addr=3 and rf_wr_en=16'hFFFF in N+1 only.
  - rf_wr_en=0 in N+2.
- Both valid for 4 cycles, addr 1 and 2:
  - RR build: grants 0,1,0,1, and each requester holds until granted.
  - Non-RR build: grants 1,1,1,1.
- Reserve reg 7 (cycle N):
  - busy[7]=1 in N+1.
  - A second reservation of 7 sees rsv_ready=0.
  - Writeback to 7 with be=0 in cycle M: busy[7]=0 in M+1.
- Same-cycle writeback to 5 and reservation of 5 while busy[5]=1: rsv_ready=1, and busy[5] remains 1 next cycle.
- Assert rst in the same cycle as an accepted transfer to reg 9: rf_wr_en=0 and busy=0 in the next cycle, and no write to reg 9.
